// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Groups the requester handshakes and the dmem control bus of the
//   data-memory arbiter into one bundle.
//   Requester side : REQx/WEx/ADDRx/WDATAx in, GNTx/DONEx/RDATAx out.
//   Memory side    : MEM_ADDR/MEM_WDATA/MEM_READ/MEM_WRITE out, MEM_RDATA in.
//   Status         : BUSY out.
//   Modport slave is the arbiter; modport master is whatever surrounds it
//   (requesters plus the memory).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              REQ0;
  logic              REQ1;
  logic              WE0;
  logic              WE1;
  logic [ADDR_W-1:0] ADDR0;
  logic [ADDR_W-1:0] ADDR1;
  logic [DATA_W-1:0] WDATA0;
  logic [DATA_W-1:0] WDATA1;
  logic              GNT0;
  logic              GNT1;
  logic              DONE0;
  logic              DONE1;
  logic [DATA_W-1:0] RDATA0;
  logic [DATA_W-1:0] RDATA1;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              BUSY;

  modport slave (
    input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, MEM_RDATA,
    output GNT0, GNT1, DONE0, DONE1, RDATA0, RDATA1,
           MEM_ADDR, MEM_WDATA, MEM_READ, MEM_WRITE, BUSY
  );

  modport master (
    output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, MEM_RDATA,
    input  GNT0, GNT1, DONE0, DONE1, RDATA0, RDATA1,
           MEM_ADDR, MEM_WDATA, MEM_READ, MEM_WRITE, BUSY
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-requester arbiter and sequencer for the single-port data memory.
//   Port 0 is the CPU data port, port 1 the loader/debug port. One winner
//   is picked in IDLE, its request is latched, the dmem controls are held
//   for MEM_LAT cycles (ACCESS), then a DONE pulse is issued (RESP).
//   Ports:
//     CLOCK   - system clock, rising edge
//     RESET_N - asynchronous active-low reset
//     bus     - dmem_arbiter_if.slave: requester handshakes, dmem bus, BUSY
//   Every output is driven straight from a flop.
module dmem_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_LAT   = 1,
  parameter int FIXED_PRI = 0
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  dmem_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              busy_q, busy_d;
  logic              pick1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    we_d        = we_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;

    // Port 1 wins when it is alone, or on a tie in round-robin mode when
    // port 0 was the last winner.
    pick1 = bus.REQ1 && (!bus.REQ0 || ((FIXED_PRI == 0) && !last_q));

    case (state_q)
      IDLE: begin
        if (bus.REQ0 || bus.REQ1) begin
          sel_d       = pick1;
          we_d        = pick1 ? bus.WE1    : bus.WE0;
          addr_d      = pick1 ? bus.ADDR1  : bus.ADDR0;
          wdata_d     = pick1 ? bus.WDATA1 : bus.WDATA0;
          cnt_d       = 4'(MEM_LAT - 1);
          gnt0_d      = !pick1;
          gnt1_d      = pick1;
          mem_read_d  = !we_d;
          mem_write_d = we_d;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        // The last hold cycle samples the combinational read data and
        // drops the memory strobes for the RESP cycle.
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          last_d  = sel_q;
          done0_d = !sel_q;
          done1_d = sel_q;
          if (!we_q) begin
            if (sel_q) rdata1_d = bus.MEM_RDATA;
            else       rdata0_d = bus.MEM_RDATA;
          end
        end else begin
          cnt_d       = cnt_q - 4'd1;
          mem_read_d  = !we_q;
          mem_write_d = we_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Last-winner pointer resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      last_q      <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.GNT0      = gnt0_q;
  assign bus.GNT1      = gnt1_q;
  assign bus.DONE0     = done0_q;
  assign bus.DONE1     = done1_q;
  assign bus.RDATA0    = rdata0_q;
  assign bus.RDATA1    = rdata1_q;
  assign bus.MEM_ADDR  = addr_q;
  assign bus.MEM_WDATA = wdata_q;
  assign bus.MEM_READ  = mem_read_q;
  assign bus.MEM_WRITE = mem_write_q;
  assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. Three instances share clock and reset:
//   a = MEM_LAT 1 round-robin, b = MEM_LAT 3 round-robin,
//   f = MEM_LAT 1 fixed priority. Each has a small behavioural dmem whose
//   reset contents hold 0xDEAD at 0x10 and 0xBEEF at 0x08.
module tb_dmem_arbiter;

  logic CLOCK = 1'b0;
  logic RESET_N = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 CLOCK = ~CLOCK;

  dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) if_a ();
  dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) if_b ();
  dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) if_f ();

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1), .FIXED_PRI(0)) dut_a (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .bus(if_a.slave));
  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3), .FIXED_PRI(0)) dut_b (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .bus(if_b.slave));
  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1), .FIXED_PRI(1)) dut_f (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .bus(if_f.slave));

  // Behavioural single-port memories, combinational read, write on edge.
  logic [63:0] mem_a [0:63];
  logic [63:0] mem_b [0:63];
  logic [63:0] mem_f [0:63];

  always @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= 64'h0;
      mem_a[6'h10] <= 64'hDEAD;
      mem_a[6'h08] <= 64'hBEEF;
    end else if (if_a.MEM_WRITE) mem_a[if_a.MEM_ADDR[5:0]] <= if_a.MEM_WDATA;
  end
  always @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 64; i++) mem_b[i] <= 64'h0;
      mem_b[6'h10] <= 64'hDEAD;
      mem_b[6'h08] <= 64'hBEEF;
    end else if (if_b.MEM_WRITE) mem_b[if_b.MEM_ADDR[5:0]] <= if_b.MEM_WDATA;
  end
  always @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 64; i++) mem_f[i] <= 64'h0;
      mem_f[6'h10] <= 64'hDEAD;
      mem_f[6'h08] <= 64'hBEEF;
    end else if (if_f.MEM_WRITE) mem_f[if_f.MEM_ADDR[5:0]] <= if_f.MEM_WDATA;
  end

  assign if_a.MEM_RDATA = mem_a[if_a.MEM_ADDR[5:0]];
  assign if_b.MEM_RDATA = mem_b[if_b.MEM_ADDR[5:0]];
  assign if_f.MEM_RDATA = mem_f[if_f.MEM_ADDR[5:0]];

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic pulse_reset;
    RESET_N = 1'b0;
    #2;
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic idle_inputs;
    if_a.REQ0 = 0; if_a.REQ1 = 0; if_a.WE0 = 0; if_a.WE1 = 0;
    if_a.ADDR0 = 0; if_a.ADDR1 = 0; if_a.WDATA0 = 0; if_a.WDATA1 = 0;
    if_b.REQ0 = 0; if_b.REQ1 = 0; if_b.WE0 = 0; if_b.WE1 = 0;
    if_b.ADDR0 = 0; if_b.ADDR1 = 0; if_b.WDATA0 = 0; if_b.WDATA1 = 0;
    if_f.REQ0 = 0; if_f.REQ1 = 0; if_f.WE0 = 0; if_f.WE1 = 0;
    if_f.ADDR0 = 0; if_f.ADDR1 = 0; if_f.WDATA0 = 0; if_f.WDATA1 = 0;
  endtask

  task automatic test_reset;
    logic [6:0] ctl;
    ctl = {if_a.GNT0, if_a.GNT1, if_a.DONE0, if_a.DONE1, if_a.MEM_READ, if_a.MEM_WRITE, if_a.BUSY};
    checks++; if (ctl !== 7'd0) begin errors++; $display("[TB] FAIL reset_ctl_a: got %b expected 0", ctl); end
    checks++; if (if_a.RDATA0 !== 64'h0 || if_a.RDATA1 !== 64'h0) begin errors++; $display("[TB] FAIL reset_rdata_a: got %h/%h expected 0", if_a.RDATA0, if_a.RDATA1); end
    checks++; if (if_a.MEM_ADDR !== 64'h0 || if_a.MEM_WDATA !== 64'h0) begin errors++; $display("[TB] FAIL reset_mem_a: got %h/%h expected 0", if_a.MEM_ADDR, if_a.MEM_WDATA); end
    ctl = {if_b.GNT0, if_b.GNT1, if_b.DONE0, if_b.DONE1, if_b.MEM_READ, if_b.MEM_WRITE, if_b.BUSY};
    checks++; if (ctl !== 7'd0) begin errors++; $display("[TB] FAIL reset_ctl_b: got %b expected 0", ctl); end
  endtask

  task automatic test_read;
    if_a.REQ0 = 1; if_a.WE0 = 0; if_a.ADDR0 = 64'h10;
    tick();
    checks++; if ({if_a.GNT0, if_a.GNT1} !== 2'b10) begin errors++; $display("[TB] FAIL rd_gnt: got %b expected 10", {if_a.GNT0, if_a.GNT1}); end
    checks++; if ({if_a.MEM_READ, if_a.MEM_WRITE, if_a.BUSY} !== 3'b101) begin errors++; $display("[TB] FAIL rd_ctl_c1: got %b expected 101", {if_a.MEM_READ, if_a.MEM_WRITE, if_a.BUSY}); end
    checks++; if (if_a.MEM_ADDR !== 64'h10) begin errors++; $display("[TB] FAIL rd_addr: got %h expected 10", if_a.MEM_ADDR); end
    if_a.REQ0 = 0;
    tick();
    checks++; if ({if_a.DONE0, if_a.DONE1, if_a.GNT0, if_a.MEM_READ, if_a.BUSY} !== 5'b10001) begin errors++; $display("[TB] FAIL rd_ctl_c2: got %b expected 10001", {if_a.DONE0, if_a.DONE1, if_a.GNT0, if_a.MEM_READ, if_a.BUSY}); end
    checks++; if (if_a.RDATA0 !== 64'hDEAD) begin errors++; $display("[TB] FAIL rd_data: got %h expected dead", if_a.RDATA0); end
    tick();
    checks++; if ({if_a.DONE0, if_a.BUSY} !== 2'b00 || if_a.RDATA0 !== 64'hDEAD) begin errors++; $display("[TB] FAIL rd_idle: got %b %h expected 00 dead", {if_a.DONE0, if_a.BUSY}, if_a.RDATA0); end
  endtask

  task automatic test_write;
    if_a.REQ1 = 1; if_a.WE1 = 1; if_a.ADDR1 = 64'h20; if_a.WDATA1 = 64'h1234;
    tick();
    checks++; if ({if_a.GNT0, if_a.GNT1, if_a.MEM_READ, if_a.MEM_WRITE} !== 4'b0101) begin errors++; $display("[TB] FAIL wr_c1: got %b expected 0101", {if_a.GNT0, if_a.GNT1, if_a.MEM_READ, if_a.MEM_WRITE}); end
    checks++; if (if_a.MEM_ADDR !== 64'h20 || if_a.MEM_WDATA !== 64'h1234) begin errors++; $display("[TB] FAIL wr_bus: got %h/%h expected 20/1234", if_a.MEM_ADDR, if_a.MEM_WDATA); end
    if_a.REQ1 = 0;
    tick();
    checks++; if ({if_a.DONE0, if_a.DONE1, if_a.MEM_READ, if_a.MEM_WRITE} !== 4'b0100) begin errors++; $display("[TB] FAIL wr_c2: got %b expected 0100", {if_a.DONE0, if_a.DONE1, if_a.MEM_READ, if_a.MEM_WRITE}); end
    checks++; if (if_a.RDATA1 !== 64'h0) begin errors++; $display("[TB] FAIL wr_rdata_kept: got %h expected 0", if_a.RDATA1); end
    tick();
    if_a.REQ0 = 1; if_a.WE0 = 0; if_a.ADDR0 = 64'h20;
    tick();
    if_a.REQ0 = 0;
    tick();
    checks++; if (if_a.DONE0 !== 1'b1 || if_a.RDATA0 !== 64'h1234) begin errors++; $display("[TB] FAIL wr_readback: got %b %h expected 1 1234", if_a.DONE0, if_a.RDATA0); end
    tick();
  endtask

  task automatic test_round_robin;
    int order[$];
    int done_cyc[$];
    bit both = 0;
    pulse_reset();
    if_a.REQ0 = 1; if_a.WE0 = 0; if_a.ADDR0 = 64'h10;
    if_a.REQ1 = 1; if_a.WE1 = 0; if_a.ADDR1 = 64'h08;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (if_a.GNT0 && if_a.GNT1) both = 1;
      if (if_a.GNT0) order.push_back(0);
      if (if_a.GNT1) order.push_back(1);
      if (if_a.DONE0 || if_a.DONE1) done_cyc.push_back(c);
    end
    if_a.REQ0 = 0; if_a.REQ1 = 0;
    checks++; if (both !== 1'b0) begin errors++; $display("[TB] FAIL rr_both_gnt: got 1 expected 0"); end
    checks++; if (order.size() != 4) begin errors++; $display("[TB] FAIL rr_count: got %0d expected 4", order.size()); end
    for (int i = 0; i < order.size() && i < 4; i++) begin
      checks++; if (order[i] != (i % 2)) begin errors++; $display("[TB] FAIL rr_order%0d: got %0d expected %0d", i, order[i], i % 2); end
    end
    checks++; if (done_cyc.size() != 4) begin errors++; $display("[TB] FAIL rr_done_count: got %0d expected 4", done_cyc.size()); end
    else if (done_cyc[0] != 2 || done_cyc[1] != 5 || done_cyc[2] != 8 || done_cyc[3] != 11) begin
      errors++; $display("[TB] FAIL rr_done_spacing: got %0d,%0d,%0d,%0d expected 2,5,8,11", done_cyc[0], done_cyc[1], done_cyc[2], done_cyc[3]);
    end
    checks++; if (if_a.RDATA0 !== 64'hDEAD || if_a.RDATA1 !== 64'hBEEF) begin errors++; $display("[TB] FAIL rr_rdata: got %h/%h expected dead/beef", if_a.RDATA0, if_a.RDATA1); end
    tick();
    tick();
  endtask

  task automatic test_fixed_priority;
    int g0 = 0;
    int g1 = 0;
    if_f.REQ0 = 1; if_f.WE0 = 0; if_f.ADDR0 = 64'h10;
    if_f.REQ1 = 1; if_f.WE1 = 0; if_f.ADDR1 = 64'h08;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (if_f.GNT0) g0++;
      if (if_f.GNT1) g1++;
    end
    checks++; if (g0 != 3 || g1 != 0) begin errors++; $display("[TB] FAIL fp_grants: got g0=%0d g1=%0d expected g0=3 g1=0", g0, g1); end
    if_f.REQ0 = 0;
    tick();
    checks++; if ({if_f.GNT0, if_f.GNT1, if_f.BUSY} !== 3'b000) begin errors++; $display("[TB] FAIL fp_idle: got %b expected 000", {if_f.GNT0, if_f.GNT1, if_f.BUSY}); end
    tick();
    checks++; if ({if_f.GNT0, if_f.GNT1} !== 2'b01) begin errors++; $display("[TB] FAIL fp_gnt1: got %b expected 01", {if_f.GNT0, if_f.GNT1}); end
    if_f.REQ1 = 0;
    tick();
    tick();
  endtask

  task automatic test_latency;
    if_b.REQ0 = 1; if_b.WE0 = 0; if_b.ADDR0 = 64'h08;
    tick();
    checks++; if (if_b.GNT0 !== 1'b1) begin errors++; $display("[TB] FAIL lat_gnt: got %b expected 1", if_b.GNT0); end
    if_b.REQ0 = 0; if_b.ADDR0 = 64'h99;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) tick();
      checks++; if ({if_b.MEM_READ, if_b.MEM_WRITE, if_b.DONE0} !== 3'b100 || if_b.MEM_ADDR !== 64'h08) begin
        errors++; $display("[TB] FAIL lat_access%0d: got %b %h expected 100 8", c, {if_b.MEM_READ, if_b.MEM_WRITE, if_b.DONE0}, if_b.MEM_ADDR);
      end
    end
    tick();
    checks++; if ({if_b.DONE0, if_b.MEM_READ} !== 2'b10 || if_b.RDATA0 !== 64'hBEEF) begin errors++; $display("[TB] FAIL lat_done: got %b %h expected 10 beef", {if_b.DONE0, if_b.MEM_READ}, if_b.RDATA0); end
    tick();
    checks++; if (if_b.BUSY !== 1'b0) begin errors++; $display("[TB] FAIL lat_idle: got %b expected 0", if_b.BUSY); end
  endtask

  task automatic test_reset_mid;
    logic [6:0] ctl;
    bit stray = 0;
    if_b.REQ1 = 1; if_b.WE1 = 0; if_b.ADDR1 = 64'h08;
    tick();
    if_b.REQ1 = 0;
    tick();
    #2;
    RESET_N = 1'b0;
    #1;
    ctl = {if_b.GNT0, if_b.GNT1, if_b.DONE0, if_b.DONE1, if_b.MEM_READ, if_b.MEM_WRITE, if_b.BUSY};
    checks++; if (ctl !== 7'd0) begin errors++; $display("[TB] FAIL rst_mid_ctl: got %b expected 0", ctl); end
    checks++; if (if_b.RDATA0 !== 64'h0 || if_b.MEM_ADDR !== 64'h0) begin errors++; $display("[TB] FAIL rst_mid_data: got %h/%h expected 0", if_b.RDATA0, if_b.MEM_ADDR); end
    #2;
    RESET_N = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (if_b.DONE0 || if_b.DONE1 || if_b.MEM_READ || if_b.MEM_WRITE || if_b.BUSY) stray = 1;
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_quiet: got 1 expected 0"); end
    if_b.REQ0 = 1; if_b.WE0 = 0; if_b.ADDR0 = 64'h10;
    if_b.REQ1 = 1;
    tick();
    checks++; if ({if_b.GNT0, if_b.GNT1} !== 2'b10) begin errors++; $display("[TB] FAIL rst_mid_first: got %b expected 10", {if_b.GNT0, if_b.GNT1}); end
    if_b.REQ0 = 0; if_b.REQ1 = 0;
    tick(); tick(); tick();
    checks++; if (if_b.DONE0 !== 1'b1 || if_b.RDATA0 !== 64'hDEAD) begin errors++; $display("[TB] FAIL rst_mid_done: got %b %h expected 1 dead", if_b.DONE0, if_b.RDATA0); end
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    idle_inputs();
    #1;
    RESET_N = 1'b0;
    #13;
    RESET_N = 1'b1;
    tick();
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_fixed_priority();
    test_latency();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port data memory (dmem). Port 0 is the CPU data port; port 1 is the loader/debug port that preloads or inspects dmem. The block picks one requester, drives dmem's address, write-data and MEMREAD/MEMWRITE lines for a configurable number of cycles, then returns read data with a done pulse.

Parameters:
ADDR_W, 64, address width (matches ALU_Result_Out).
DATA_W, 64, data width.
MEM_LAT, 1, cycles the memory controls are held per access (legal 1..15).
FIXED_PRI, 0, arbitration mode: 0 = round-robin, 1 = port 0 always wins ties.

Ports:
CLOCK  in  1  system clock, rising edge.
RESET_N  in  1  asynchronous active-low reset.
REQ0 / REQ1  in  1  access request, port 0 / port 1.
WE0 / WE1  in  1  1 = write, 0 = read; valid while REQx is high.
ADDR0 / ADDR1  in  ADDR_W  byte address.
WDATA0 / WDATA1  in  DATA_W  write data.
GNT0 / GNT1  out  1  one-cycle grant pulse.
DONE0 / DONE1  out  1  one-cycle completion pulse.
RDATA0 / RDATA1  out  DATA_W  read result; valid from DONEx and held until that port's next read completes.
MEM_ADDR  out  ADDR_W  to dmem address.
MEM_WDATA  out  DATA_W  to dmem write data.
MEM_READ  out  1  to dmem MEMREAD.
MEM_WRITE  out  1  to dmem MEMWRITE.
MEM_RDATA  in  DATA_W  from dmem data out (combinational read).
BUSY  out  1  high whenever state != IDLE.

Behaviour:
- Reset (RESET_N low, asynchronous): state IDLE and all outputs 0, including RDATA0/1. The last-winner pointer resets to 1, so port 0 wins the first tie. Assertion mid-transaction abandons it: no DONE and no further MEM_* activity.
- All outputs are registered.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - At each rising edge, if REQ0 or REQ1 is high, select a winner and latch its WE/ADDR/WDATA. Load the latency counter with MEM_LAT-1 and go to ACCESS.
  - If no request is high, stay in IDLE.
- Arbitration:
  - Only one requester high: it wins.
  - Both high, FIXED_PRI=1: port 0 wins.
  - Both high, FIXED_PRI=0: the port that is not the last winner wins.
  - The last-winner pointer updates on entry to RESP.
- ACCESS:
  - GNTx is high during the first ACCESS cycle only.
  - MEM_ADDR and MEM_WDATA carry the latched values for all MEM_LAT cycles.
  - MEM_READ = !WE and MEM_WRITE = WE (latched WE) for those cycles; the two are never both high.
  - The counter decrements each edge. At the edge where it reads 0, a read captures MEM_RDATA into RDATAx (a write leaves RDATAx unchanged) and the state goes to RESP.
- RESP:
  - DONEx high for one cycle, with MEM_READ/MEM_WRITE low.
  - Next state is IDLE unconditionally.
- Outside ACCESS: MEM_READ=MEM_WRITE=0, and MEM_ADDR/MEM_WDATA hold their last values.
- Timing: the REQ-sampling edge is edge 0.
  - GNT is visible in cycle 1.
  - MEM_* are active in cycles 1..MEM_LAT.
  - DONE is in cycle MEM_LAT+1.
  - IDLE is in cycle MEM_LAT+2, and its closing edge samples the next request. Throughput is one access per MEM_LAT+2 cycles.
- Requester rules:
  - Hold REQ and the request fields stable until GNT. Fields may change after GNT, since they are latched.
  - REQ still high in the IDLE cycle after DONE counts as a new request.
  - A losing requester keeps REQ high and is served next (round-robin mode).
- Request changes during ACCESS/RESP are ignored until the next IDLE sample.
- MEM_LAT outside 1..15 is unsupported; the bench does not exercise it.

Test Plan:
1. MEM_LAT=1, REQ0=1, WE0=0, ADDR0=0x10, dmem[0x10]=0xDEAD -> GNT0 and MEM_READ in cycle 1 with MEM_ADDR=0x10; DONE0 in cycle 2 with RDATA0=0xDEAD; BUSY high in cycles 1-2.
2. Write via port 1: REQ1=1, WE1=1, ADDR1=0x20, WDATA1=0x1234 -> MEM_WRITE=1 for one cycle and MEM_READ=0 throughout; DONE1 pulses; a subsequent port-0 read of 0x20 returns 0x1234.
3. Round-robin: REQ0 and REQ1 both held high, 4 reads -> grant order 0,1,0,1; each DONE is 3 cycles after its predecessor; no cycle has both GNT0 and GNT1 high.
4. FIXED_PRI=1 with REQ0 and REQ1 both held high -> GNT0 every transaction and GNT1 never; dropping REQ0 -> GNT1 at the next IDLE sample.
5. MEM_LAT=3 read at 0x08 with dmem=0xBEEF -> MEM_READ high for exactly 3 cycles and MEM_ADDR stable at 0x08; DONE0 in cycle 4 with RDATA0=0xBEEF.
6. RESET_N pulsed low during the 2nd ACCESS cycle with MEM_LAT=3 -> all outputs 0 immediately (asynchronously) and no DONE; after release with both REQs high, port 0 is granted first.
